// File: rtl/pipe_run_ctrl.sv
// Run/step/halt sequencer driving pipe_en for data_route; optional step debounce via STEP_DEBOUNCE_EN.
// Latency: board inputs reach pipe_en 3 clk1 edges after they change (plus DEB_CYCLES when debounced).
// Backpressure: none; pipe_en is a free-running enable and halt_req stops it on the next edge.
module pipe_run_ctrl #(
  parameter int unsigned DIV_LOG2   = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             frequency,
  input  logic             halt_req,
  output logic             pipe_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  logic                run_meta;
  logic                run_s;
  logic                step_meta;
  logic                step_s;
  logic                step_clean;
  logic                step_s_d;
  logic                step_pulse;
  logic [1:0]          next_state;
  logic [DIV_LOG2-1:0] div_cnt;
  logic                freq_d;
  logic                freq_chg;
  logic                run_entry;
  logic                tick;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
    end else begin
      run_meta  <= run_sw;
      run_s     <= run_meta;
      step_meta <= step_btn;
      step_s    <= step_meta;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt;
  logic             step_db;

  // The output only follows the input after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      step_db <= 1'b0;
    end else if (step_s == step_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      step_db <= step_s;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign step_clean = step_db;
`else
  assign step_clean = step_s;
`endif

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      step_s_d <= 1'b0;
    end else begin
      step_s_d <= step_clean;
    end
  end

  assign step_pulse = step_clean & ~step_s_d;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (run_s) begin
          next_state = ST_RUN;
        end else if (step_pulse) begin
          next_state = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          next_state = ST_HALT;
        end else if (!run_s) begin
          next_state = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          next_state = ST_HALT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        // HALT ignores step presses; only a low run switch releases it.
        if (!run_s) begin
          next_state = ST_IDLE;
        end
      end
    endcase
  end

  assign freq_chg  = (frequency != freq_d);
  assign run_entry = (state != ST_RUN) && (next_state == ST_RUN);

  // The divider starts from zero on entry, so the first slow tick lands one full period in.
  assign tick = frequency ||
                ((state == ST_RUN) && !freq_chg && (div_cnt == {DIV_LOG2{1'b1}}));

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      freq_d  <= 1'b0;
      div_cnt <= '0;
    end else begin
      freq_d <= frequency;
      if (run_entry || freq_chg) begin
        div_cnt <= '0;
      end else if (next_state == ST_RUN) begin
        div_cnt <= div_cnt + DIV_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pipe_en <= 1'b0;
    end else begin
      state   <= next_state;
      pipe_en <= ((next_state == ST_RUN) && tick) || (next_state == ST_STEP);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (pipe_en && (cycle_cnt != {CNT_W{1'b1}})) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: a default instance plus a 4-bit counter instance for saturation.
module tb_pipe_run_ctrl;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        frequency = 1'b1;
  logic        halt_req = 1'b0;
  logic        pipe_en;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic        sat_pipe_en;
  logic [1:0]  sat_state;
  logic [3:0]  sat_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 clk1 = ~clk1;

  pipe_run_ctrl #(.DIV_LOG2(4), .CNT_W(32), .DEB_CYCLES(16)) dut (
    .clk1(clk1), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .frequency(frequency), .halt_req(halt_req),
    .pipe_en(pipe_en), .state(state), .cycle_cnt(cycle_cnt)
  );

  pipe_run_ctrl #(.DIV_LOG2(4), .CNT_W(4), .DEB_CYCLES(16)) dut_sat (
    .clk1(clk1), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .frequency(frequency), .halt_req(halt_req),
    .pipe_en(sat_pipe_en), .state(sat_state), .cycle_cnt(sat_cnt)
  );

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic test_reset;
    run_sw = 1'b1;
    rst = 1'b1;
    wait_n(3);
    tests++; if (pipe_en !== 1'b0) begin fails++; $display("FAIL reset_pipe_en got %b want 0", pipe_en); end
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state got %b want 00", state); end
    tests++; if (cycle_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cycle_cnt); end
    rst = 1'b0;
    wait_n(2);
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_sync_delay got %b want 00", state); end
    wait_n(1);
    tests++; if (state !== 2'b01 || pipe_en !== 1'b1) begin
      fails++; $display("FAIL reset_run_entry got state=%b en=%b want 01/1", state, pipe_en);
    end
    run_sw = 1'b0;
    wait_n(6);
    exp_cnt += 3;
    tests++; if (state !== 2'b00 || cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL reset_exit got state=%b cnt=%0d want 00/%0d", state, cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_full_rate;
    int highs = 0;
    int first = 0;
    int last = 0;
    frequency = 1'b1;
    run_sw = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk1);
      if (pipe_en) begin
        highs++;
        if (first == 0) first = i;
        last = i;
      end
      if (i == 20) run_sw = 1'b0;
    end
    exp_cnt += 20;
    tests++; if (highs !== 20 || first !== 3 || last !== 22) begin
      fails++; $display("FAIL full_rate_en got highs=%0d first=%0d last=%0d want 20/3/22", highs, first, last);
    end
    tests++; if (state !== 2'b00 || cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL full_rate_cnt got state=%b cnt=%0d want 00/%0d", state, cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_slow_rate;
    int highs = 0;
    int first = 0;
    int prev = 0;
    int bad_gap = 0;
    frequency = 1'b0;
    run_sw = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk1);
      if (pipe_en) begin
        highs++;
        if (first == 0) first = i;
        else if (i - prev != 16) bad_gap++;
        prev = i;
      end
      if (i == 70) run_sw = 1'b0;
    end
    exp_cnt += 4;
    tests++; if (highs !== 4 || first !== 19 || bad_gap !== 0) begin
      fails++; $display("FAIL slow_rate_pulses got n=%0d first=%0d badgaps=%0d want 4/19/0", highs, first, bad_gap);
    end
    tests++; if (state !== 2'b00 || cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL slow_rate_cnt got state=%b cnt=%0d want 00/%0d", state, cycle_cnt, exp_cnt);
    end
    frequency = 1'b1;
  endtask

  task automatic test_step;
    int highs = 0;
    int in_step = 0;
    int width = 0;
    int max_w = 0;
    run_sw = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 48; i++) begin
        step_btn = (i < 24);
        @(negedge clk1);
        if (pipe_en) begin
          highs++;
          width++;
          if (state == 2'b10) in_step++;
        end else begin
          width = 0;
        end
        if (width > max_w) max_w = width;
      end
    end
    exp_cnt += 3;
    tests++; if (highs !== 3 || max_w !== 1 || in_step !== 3) begin
      fails++; $display("FAIL step_pulses got n=%0d maxw=%0d instep=%0d want 3/1/3", highs, max_w, in_step);
    end
    tests++; if (state !== 2'b00 || cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL step_cnt got state=%b cnt=%0d want 00/%0d", state, cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_step_with_run;
    int highs = 0;
    run_sw = 1'b1;
    step_btn = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk1);
      if (pipe_en) highs++;
      if (i == 3) begin
        tests++; if (state !== 2'b01) begin
          fails++; $display("FAIL coincident_state got %b want 01", state);
        end
      end
      if (i == 30) begin
        run_sw = 1'b0;
        step_btn = 1'b0;
      end
    end
    exp_cnt += 30;
    tests++; if (highs !== 30 || cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL coincident_pulses got n=%0d cnt=%0d want 30/%0d", highs, cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_halt;
    int highs = 0;
    frequency = 1'b1;
    run_sw = 1'b1;
    wait_n(5);
    tests++; if (state !== 2'b01 || pipe_en !== 1'b1) begin
      fails++; $display("FAIL halt_pre_run got state=%b en=%b want 01/1", state, pipe_en);
    end
    halt_req = 1'b1;
    wait_n(1);
    halt_req = 1'b0;
    tests++; if (state !== 2'b11 || pipe_en !== 1'b0) begin
      fails++; $display("FAIL halt_enter got state=%b en=%b want 11/0", state, pipe_en);
    end
    for (int i = 0; i < 96; i++) begin
      step_btn = ((i % 48) < 24);
      @(negedge clk1);
      if (pipe_en) highs++;
    end
    step_btn = 1'b0;
    tests++; if (highs !== 0 || state !== 2'b11) begin
      fails++; $display("FAIL halt_step_ignored got n=%0d state=%b want 0/11", highs, state);
    end
    run_sw = 1'b0;
    wait_n(4);
    tests++; if (state !== 2'b00) begin fails++; $display("FAIL halt_release got %b want 00", state); end
    run_sw = 1'b1;
    wait_n(4);
    tests++; if (state !== 2'b01 || pipe_en !== 1'b1) begin
      fails++; $display("FAIL halt_resume got state=%b en=%b want 01/1", state, pipe_en);
    end
    run_sw = 1'b0;
    wait_n(8);
    exp_cnt += 7;
    tests++; if (state !== 2'b00 || cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL halt_cnt got state=%b cnt=%0d want 00/%0d", state, cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_step_filter;
    int highs = 0;
`ifdef STEP_DEBOUNCE_EN
    for (int i = 0; i < 45; i++) begin
      step_btn = (i < 5);
      @(negedge clk1);
      if (pipe_en) highs++;
    end
    tests++; if (highs !== 0) begin fails++; $display("FAIL debounce_glitch got n=%0d want 0", highs); end
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      step_btn = (i < 20);
      @(negedge clk1);
      if (pipe_en) highs++;
    end
    tests++; if (highs !== 1) begin fails++; $display("FAIL debounce_press got n=%0d want 1", highs); end
`else
    for (int i = 0; i < 12; i++) begin
      step_btn = (i < 2);
      @(negedge clk1);
      if (pipe_en) highs++;
    end
    tests++; if (highs !== 1) begin fails++; $display("FAIL short_press got n=%0d want 1", highs); end
`endif
    exp_cnt += 1;
    step_btn = 1'b0;
    tests++; if (cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL step_filter_cnt got %0d want %0d", cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturation;
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    exp_cnt = 0;
    tests++; if (sat_cnt !== 4'd0 || cycle_cnt !== 32'd0) begin
      fails++; $display("FAIL sat_reset got sat=%0d cnt=%0d want 0/0", sat_cnt, cycle_cnt);
    end
    frequency = 1'b1;
    run_sw = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk1);
      if (i == 18) begin
        tests++; if (sat_cnt !== 4'd15) begin fails++; $display("FAIL sat_reach got %0d want 15", sat_cnt); end
      end
    end
    run_sw = 1'b0;
    wait_n(10);
    exp_cnt += 30;
    tests++; if (sat_cnt !== 4'd15 || cycle_cnt !== 32'(exp_cnt)) begin
      fails++; $display("FAIL sat_hold got sat=%0d cnt=%0d want 15/%0d", sat_cnt, cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_abort;
    frequency = 1'b1;
    run_sw = 1'b1;
    wait_n(5);
    tests++; if (pipe_en !== 1'b1) begin fails++; $display("FAIL abort_pre got en=%b want 1", pipe_en); end
    #2 rst = 1'b1;
    #1;
    tests++; if (pipe_en !== 1'b0 || state !== 2'b00 || cycle_cnt !== 32'd0) begin
      fails++; $display("FAIL abort_async got en=%b state=%b cnt=%0d want 0/00/0", pipe_en, state, cycle_cnt);
    end
    @(negedge clk1);
    run_sw = 1'b0;
    rst = 1'b0;
    wait_n(4);
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_slow_rate();
    test_step();
    test_step_with_run();
    test_halt();
    test_step_filter();
    test_saturation();
    test_async_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
